// File: rtl/tv80_alu16_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tv80_alu16_seq
//  Purpose  : Two-pass sequencer for 16-bit arithmetic on the 8-bit TV80 ALU.
//             ADD HL,rr / ADC HL,rr / SBC HL,rr / ADD SP,e8 are split into a
//             low-byte pass (LO) followed by a high-byte pass (HI). The ALU
//             itself is external and combinational; this block drives its
//             inputs from registered state and captures Q/F_Out at the end
//             of each pass.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset_n            clock, asynchronous active-low reset
//    start, op, a16, b16,    request handshake and operands (accepted when
//    f_in                    ready=1; op 00 ADD16, 01 ADC16, 10 SBC16,
//                            11 ADDSP with b16[7:0]=e8)
//    flush                   synchronous abort back to IDLE, no done
//    ready, done             idle indicator, one-cycle result-valid pulse
//    result, f_res           16-bit result and final flags (f_res[3:0]=0)
//    alu_op, alu_bus_a,      drive to ALU ALU_Op/BusA/BusB/F_In/Arith16/Z16
//    alu_bus_b, alu_f,       (all zero in IDLE and DONE)
//    alu_arith16, alu_z16
//    alu_q, alu_f_out        ALU Q/F_Out, captured at the end of LO and HI
//  Configuration
//    TV80_ALU16_ADDSP_EN     when defined, op 11 performs ADD SP,e8
//                            (sign-extended e8, flags from the low pass with
//                            Z=N=0); when undefined op 11 behaves as ADD16.
// ============================================================================
module tv80_alu16_seq #(
    parameter int Mode   = 3,
    parameter int Flag_C = 4,
    parameter int Flag_H = 5,
    parameter int Flag_N = 6,
    parameter int Flag_Z = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] a16,
    input  logic [15:0] b16,
    input  logic [7:0]  f_in,
    input  logic        flush,
    output logic        ready,
    output logic        done,
    output logic [15:0] result,
    output logic [7:0]  f_res,
    output logic [3:0]  alu_op,
    output logic [7:0]  alu_bus_a,
    output logic [7:0]  alu_bus_b,
    output logic [7:0]  alu_f,
    output logic        alu_arith16,
    output logic        alu_z16,
    input  logic [7:0]  alu_q,
    input  logic [7:0]  alu_f_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] c_alu_add = 4'b0000;
    localparam logic [3:0] c_alu_adc = 4'b0001;
    localparam logic [3:0] c_alu_sbc = 4'b0011;

    // Mode only documents the core flavour; the sequencing is identical for
    // every mode, so nothing is elaborated differently.
    generate
        if (Mode != 3) begin : g_non_gb_mode
        end
    endgenerate

    state_t      state_q,  state_d;
    logic [1:0]  op_q,     op_d;
    logic [15:0] a_q,      a_d;
    logic [15:0] b_q,      b_d;
    logic [7:0]  flags_q,  flags_d;
    logic [7:0]  res_lo_q, res_lo_d;
    logic [7:0]  f_lo_q,   f_lo_d;
    logic [15:0] result_q, result_d;
    logic [7:0]  f_res_q,  f_res_d;

    logic        is_add16;
    logic        is_adc16;
    logic        is_sbc16;
    logic        is_addsp;
    logic [7:0]  b_hi;
    logic [7:0]  f_final;

    // Only the four architectural flags survive into f_res; bits [3:0] are
    // always cleared.
    function automatic logic [7:0] keep_flags(input logic [7:0] f);
        logic [7:0] r;
        r         = 8'h00;
        r[Flag_C] = f[Flag_C];
        r[Flag_H] = f[Flag_H];
        r[Flag_N] = f[Flag_N];
        r[Flag_Z] = f[Flag_Z];
        return r;
    endfunction

    assign is_adc16 = (op_q == 2'b01);
    assign is_sbc16 = (op_q == 2'b10);

`ifdef TV80_ALU16_ADDSP_EN
    assign is_addsp = (op_q == 2'b11);
    assign is_add16 = (op_q == 2'b00);
    // e8 is signed: the high pass adds its sign extension plus the low carry.
    assign b_hi     = is_addsp ? {8{b_q[7]}} : b_q[15:8];

    always_comb begin
        f_final = keep_flags(alu_f_out);
        if (is_addsp) begin
            // ADD SP,e8 reports H/C from the low byte and clears Z/N.
            f_final         = keep_flags(f_lo_q);
            f_final[Flag_Z] = 1'b0;
            f_final[Flag_N] = 1'b0;
        end
    end
`else
    assign is_addsp = 1'b0;
    assign is_add16 = (op_q == 2'b00) || (op_q == 2'b11);
    assign b_hi     = b_q[15:8];
    assign f_final  = keep_flags(alu_f_out);
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        flags_d     = flags_q;
        res_lo_d    = res_lo_q;
        f_lo_d      = f_lo_q;
        result_d    = result_q;
        f_res_d     = f_res_q;

        ready       = 1'b0;
        done        = 1'b0;
        alu_op      = 4'b0000;
        alu_bus_a   = 8'h00;
        alu_bus_b   = 8'h00;
        alu_f       = 8'h00;
        alu_arith16 = 1'b0;
        alu_z16     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                // flush has priority over a simultaneous start
                if (start && !flush) begin
                    op_d    = op;
                    a_d     = a16;
                    b_d     = b16;
                    flags_d = f_in;
                    state_d = ST_LO;
                end
            end

            ST_LO: begin
                alu_bus_a   = a_q[7:0];
                alu_bus_b   = b_q[7:0];
                alu_f       = flags_q;
                alu_op      = is_sbc16 ? c_alu_sbc :
                              is_adc16 ? c_alu_adc : c_alu_add;
                alu_arith16 = is_add16;
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    res_lo_d = alu_q;
                    f_lo_d   = alu_f_out;
                    state_d  = ST_HI;
                end
            end

            ST_HI: begin
                // The low-pass carry reaches the high byte only via f_lo.
                alu_bus_a   = a_q[15:8];
                alu_bus_b   = b_hi;
                alu_f       = f_lo_q;
                alu_op      = is_sbc16 ? c_alu_sbc : c_alu_adc;
                alu_arith16 = is_add16;
                alu_z16     = is_adc16 || is_sbc16;
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    // result/f_res are committed together so an abort
                    // leaves the previous outcome fully intact.
                    result_d = {alu_q, res_lo_q};
                    f_res_d  = f_final;
                    state_d  = ST_DONE;
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            op_q     <= 2'b00;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            flags_q  <= 8'h00;
            res_lo_q <= 8'h00;
            f_lo_q   <= 8'h00;
            result_q <= 16'h0000;
            f_res_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            flags_q  <= flags_d;
            res_lo_q <= res_lo_d;
            f_lo_q   <= f_lo_d;
            result_q <= result_d;
            f_res_q  <= f_res_d;
        end
    end

    assign result = result_q;
    assign f_res  = f_res_q;

endmodule
`default_nettype wire

// File: tb/tb_tv80_alu16_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tv80_alu16_seq
//  Purpose  : Directed self-checking bench for tv80_alu16_seq. A small
//             behavioural model of the 8-bit ALU (ADD/ADC/SBC, Game Boy flag
//             layout, Arith16/Z16 handling) closes the loop; expected results
//             and flags are hand-computed constants.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tv80_alu16_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [7:0]  f_in;
    logic        flush;
    logic        ready;
    logic        done;
    logic [15:0] result;
    logic [7:0]  f_res;
    logic [3:0]  alu_op;
    logic [7:0]  alu_bus_a;
    logic [7:0]  alu_bus_b;
    logic [7:0]  alu_f;
    logic        alu_arith16;
    logic        alu_z16;
    logic [7:0]  alu_q;
    logic [7:0]  alu_f_out;

    int n_cmp = 0;
    int n_err = 0;

    tv80_alu16_seq dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .a16         (a16),
        .b16         (b16),
        .f_in        (f_in),
        .flush       (flush),
        .ready       (ready),
        .done        (done),
        .result      (result),
        .f_res       (f_res),
        .alu_op      (alu_op),
        .alu_bus_a   (alu_bus_a),
        .alu_bus_b   (alu_bus_b),
        .alu_f       (alu_f),
        .alu_arith16 (alu_arith16),
        .alu_z16     (alu_z16),
        .alu_q       (alu_q),
        .alu_f_out   (alu_f_out)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural 8-bit ALU (Z=7 N=6 H=5 C=4) --------------
    logic       m_sub;
    logic       m_cin;
    logic [8:0] m_sum;
    logic [4:0] m_half;

    always_comb begin
        m_sub  = alu_op[1];
        m_cin  = m_sub ^ (alu_op[0] & alu_f[4]);
        m_sum  = {1'b0, alu_bus_a} + {1'b0, (m_sub ? ~alu_bus_b : alu_bus_b)} + {8'd0, m_cin};
        m_half = {1'b0, alu_bus_a[3:0]} + {1'b0, (m_sub ? ~alu_bus_b[3:0] : alu_bus_b[3:0])} + {4'd0, m_cin};
        alu_q  = m_sum[7:0];
        alu_f_out    = alu_f;
        alu_f_out[6] = m_sub;
        alu_f_out[5] = m_sub ? ~m_half[4] : m_half[4];
        alu_f_out[4] = m_sub ? ~m_sum[8]  : m_sum[8];
        if (m_sum[7:0] == 8'h00)
            alu_f_out[7] = alu_z16 ? alu_f[7] : 1'b1;
        else
            alu_f_out[7] = 1'b0;
        if (alu_arith16)
            alu_f_out[7] = alu_f[7];
        // non-zero junk in the unused nibble so masking is observable
        alu_f_out[3:0] = m_sum[3:0] ^ 4'hA;
    end

    // ---------------- checking ----------------------------------------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full request; called at #1 after a rising edge with the DUT idle.
    // ctl = {alu_arith16, alu_z16}
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [15:0] a, input logic [15:0] b, input logic [7:0] f,
                          input logic [15:0] exp_res, input logic [7:0] exp_f,
                          input logic [3:0] lo_op, input logic [1:0] lo_ctl,
                          input logic [3:0] hi_op, input logic [1:0] hi_ctl,
                          input logic [7:0] exp_bhi, input bit hold_start);
        check_eq({tag, "_ready_idle"}, ready, 1);
        start = 1'b1; op = o; a16 = a; b16 = b; f_in = f;
        @(posedge clk); #1;                                  // cycle 1: LO
        if (!hold_start) start = 1'b0;
        check_eq({tag, "_lo_ready"}, ready, 0);
        check_eq({tag, "_lo_done"},  done, 0);
        check_eq({tag, "_lo_op"},    alu_op, lo_op);
        check_eq({tag, "_lo_ctl"},   {alu_arith16, alu_z16}, lo_ctl);
        check_eq({tag, "_lo_bus"},   {alu_bus_a, alu_bus_b, alu_f}, {a[7:0], b[7:0], f});
        @(posedge clk); #1;                                  // cycle 2: HI
        check_eq({tag, "_hi_done"},  done, 0);
        check_eq({tag, "_hi_op"},    alu_op, hi_op);
        check_eq({tag, "_hi_ctl"},   {alu_arith16, alu_z16}, hi_ctl);
        check_eq({tag, "_hi_bus"},   {alu_bus_a, alu_bus_b}, {a[15:8], exp_bhi});
        @(posedge clk); #1;                                  // cycle 3: DONE
        start = 1'b0;
        check_eq({tag, "_done"},     done, 1);
        check_eq({tag, "_result"},   result, exp_res);
        check_eq({tag, "_f_res"},    f_res, exp_f);
        check_eq({tag, "_done_drv"}, {alu_op, alu_bus_a, alu_bus_b, alu_f}, 0);
        @(posedge clk); #1;                                  // cycle 4: IDLE
        check_eq({tag, "_post_done"},  done, 0);
        check_eq({tag, "_post_ready"}, ready, 1);
        check_eq({tag, "_hold_res"},   result, exp_res);
    endtask

`ifdef TV80_ALU16_ADDSP_EN
    localparam logic [15:0] c_sp1_res = 16'h0000;
    localparam logic [7:0]  c_sp1_f   = 8'h30;
    localparam logic [7:0]  c_sp1_bhi = 8'h00;
    localparam logic [15:0] c_sp2_res = 16'h0FFF;
    localparam logic [7:0]  c_sp2_f   = 8'h00;
    localparam logic [7:0]  c_sp2_bhi = 8'hFF;
    localparam logic [1:0]  c_sp_ctl  = 2'b00;
`else
    // op 11 runs as ADD16 with the full b16
    localparam logic [15:0] c_sp1_res = 16'h5500;
    localparam logic [7:0]  c_sp1_f   = 8'h30;
    localparam logic [7:0]  c_sp1_bhi = 8'h55;
    localparam logic [15:0] c_sp2_res = 16'h10FF;
    localparam logic [7:0]  c_sp2_f   = 8'h80;
    localparam logic [7:0]  c_sp2_bhi = 8'h00;
    localparam logic [1:0]  c_sp_ctl  = 2'b10;
`endif

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 2'b00; a16 = 16'h0; b16 = 16'h0;
        f_in = 8'h00; flush = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_eq("rst_ready",  ready, 1);
        check_eq("rst_outs",   {done, result, f_res}, 0);
        check_eq("rst_drv",    {alu_op, alu_bus_a, alu_bus_b, alu_f, alu_arith16, alu_z16}, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        //      tag       op     a         b         f      res       f_res  lo_op  lo_ctl hi_op  hi_ctl bhi    hold
        run_op("add_a",  2'b00, 16'h0FFF, 16'h0001, 8'h80, 16'h1000, 8'hA0, 4'h0, 2'b10, 4'h1, 2'b10, 8'h00, 1'b1);
        run_op("add_b",  2'b00, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 8'h30, 4'h0, 2'b10, 4'h1, 2'b10, 8'h00, 1'b0);
        run_op("sbc",    2'b10, 16'h1000, 16'h0001, 8'h10, 16'h0FFE, 8'h60, 4'h3, 2'b00, 4'h3, 2'b01, 8'h00, 1'b0);
        run_op("adc",    2'b01, 16'hFF00, 16'h00FF, 8'h10, 16'h0000, 8'hB0, 4'h1, 2'b00, 4'h1, 2'b01, 8'h00, 1'b1);
        run_op("sp_pos", 2'b11, 16'hFFF8, 16'h5508, 8'h00, c_sp1_res, c_sp1_f, 4'h0, c_sp_ctl, 4'h1, c_sp_ctl, c_sp1_bhi, 1'b0);
        run_op("sp_neg", 2'b11, 16'h1000, 16'h00FF, 8'h80, c_sp2_res, c_sp2_f, 4'h0, c_sp_ctl, 4'h1, c_sp_ctl, c_sp2_bhi, 1'b0);

        // flush during HI: back to IDLE, no done, previous result kept
        start = 1'b1; op = 2'b00; a16 = 16'h1234; b16 = 16'h1111; f_in = 8'h00;
        @(posedge clk); #1; start = 1'b0;                    // LO
        @(posedge clk); #1; flush = 1'b1;                    // HI
        @(posedge clk); #1; flush = 1'b0;
        check_eq("flush_ready",  ready, 1);
        check_eq("flush_done",   done, 0);
        check_eq("flush_result", result, c_sp2_res);
        check_eq("flush_f_res",  f_res, c_sp2_f);
        @(posedge clk); #1;
        check_eq("flush_nodone", done, 0);

        // flush beats start in IDLE
        start = 1'b1; flush = 1'b1;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        check_eq("flush_start_ready", ready, 1);
        check_eq("flush_start_drv",   alu_bus_a, 0);

        run_op("recover", 2'b00, 16'h1234, 16'h1111, 8'h00, 16'h2345, 8'h00, 4'h0, 2'b10, 4'h1, 2'b10, 8'h11, 1'b0);

        // asynchronous reset in LO
        start = 1'b1; op = 2'b10; a16 = 16'h8000; b16 = 16'h0001; f_in = 8'h00;
        @(posedge clk); #1; start = 1'b0;                    // LO
        check_eq("pre_rst_lo", ready, 0);
        reset_n = 1'b0; #1;
        check_eq("arst_ready",  ready, 1);
        check_eq("arst_outs",   {done, result, f_res}, 0);
        check_eq("arst_drv",    {alu_op, alu_bus_a, alu_bus_b, alu_f, alu_arith16, alu_z16}, 0);
        #2; reset_n = 1'b1;
        @(posedge clk); #1;
        check_eq("arst_after_ready", ready, 1);
        check_eq("arst_after_done",  done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
